// File: rtl/uart_word_link_pkg.sv
// Shared types and helpers for the UART word link.
//   rx_state_t  : states of the receive packer
//   tx_state_t  : states of the transmit unpacker
//   level_width : bits needed to hold a count of 0..depth inclusive
package uart_word_link_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_COLLECT,
    RX_HOLD
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  // Width that can represent every value from 0 up to and including depth.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_word_link_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO. read_data always shows the head
// entry while the FIFO is not empty; read pops it.
// Ports:
//   clk, reset (sync, active-high), flush (sync clear)
//   write / write_data : push, ignored while full
//   read  / read_data  : pop, ignored while empty; read_data is the head
//   full, empty        : status flags
module sync_fifo
  import uart_word_link_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             write,
  input  logic             read,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] read_data,
  output logic             full,
  output logic             empty
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PTR_W  = level_width(DEPTH);
  localparam int ADDR_W = PTR_W - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_write;
  logic             do_read;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign do_write = write && !full;
  assign do_read  = read && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_read)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which
  // entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[ADDR_W-1:0]] <= write_data;
  end

  assign read_data = mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/uart_word_link.sv
// uart_word_link: packs received UART bytes into little-endian words and
// unpacks outgoing words into bytes, each direction buffered by a sync_fifo.
// Optional build macro: UART_WORD_LINK_STATS_EN enables the saturating
// drop/discard counters; otherwise the count ports are tied to zero.
// Ports:
//   clk, reset (sync, active-high), flush (sync clear, counters kept)
//   uart_rx_valid/uart_rx_data : byte strobe from the UART receiver
//   uart_tx_busy               : UART transmitter busy
//   uart_tx_en/uart_tx_data    : one-cycle transmit strobe and byte
//   rx_word_valid/ready/data   : packed receive word handshake
//   tx_word_valid/ready/data   : word-to-send handshake
//   rx_overrun                 : sticky, a byte was dropped on a full RX FIFO
//   rx_timeout                 : one-cycle pulse, a partial word was discarded
//   rx_overrun_count/rx_timeout_count : statistics counters
module uart_word_link
  import uart_word_link_pkg::*;
#(
  parameter int PAYLOAD_BITS = 8,
  parameter int WORD_BYTES   = 4,
  parameter int BUFFER_SIZE  = 8,
  parameter int RX_TIMEOUT   = 25000,
  parameter int CNT_BITS     = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               uart_rx_valid,
  input  logic [PAYLOAD_BITS-1:0]            uart_rx_data,
  input  logic                               uart_tx_busy,
  output logic                               uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]            uart_tx_data,
  output logic                               rx_word_valid,
  input  logic                               rx_word_ready,
  output logic [WORD_BYTES*PAYLOAD_BITS-1:0] rx_word_data,
  input  logic                               tx_word_valid,
  output logic                               tx_word_ready,
  input  logic [WORD_BYTES*PAYLOAD_BITS-1:0] tx_word_data,
  output logic                               rx_overrun,
  output logic                               rx_timeout,
  output logic [CNT_BITS-1:0]                rx_overrun_count,
  output logic [CNT_BITS-1:0]                rx_timeout_count
);

  localparam int WORD_BITS = WORD_BYTES * PAYLOAD_BITS;
  localparam int IDX_W     = level_width(WORD_BYTES);
  localparam int IDLE_W    = level_width(RX_TIMEOUT);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((RX_TIMEOUT > 0) ? RX_TIMEOUT - 1 : 0);

  // ---------------------------------------------------------------- RX path
  logic                    rx_pop;
  logic                    rx_full;
  logic                    rx_empty;
  logic                    rx_drop;
  logic                    rx_discard;
  logic [PAYLOAD_BITS-1:0] rx_head;
  rx_state_t               rx_state;
  rx_state_t               rx_state_d;
  logic [IDX_W-1:0]        rx_idx;
  logic [IDLE_W-1:0]       idle_cnt;
  logic [WORD_BITS-1:0]    rx_word;
  logic                    rx_overrun_q;
  logic                    rx_timeout_q;

  sync_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(BUFFER_SIZE)) u_rx_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .write      (uart_rx_valid),
    .read       (rx_pop),
    .write_data (uart_rx_data),
    .read_data  (rx_head),
    .full       (rx_full),
    .empty      (rx_empty)
  );

  assign rx_drop = uart_rx_valid && rx_full && !flush;

  always_ff @(posedge clk) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_state_d;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    rx_state_d = rx_state;
    rx_pop     = 1'b0;
    rx_discard = 1'b0;
    if (flush) begin
      rx_state_d = RX_IDLE;
    end else begin
      unique case (rx_state)
        RX_IDLE: begin
          if (!rx_empty) begin
            rx_pop     = 1'b1;
            rx_state_d = (WORD_BYTES == 1) ? RX_HOLD : RX_COLLECT;
          end
        end
        RX_COLLECT: begin
          if (!rx_empty) begin
            rx_pop = 1'b1;
            if (rx_idx == LAST_IDX) rx_state_d = RX_HOLD;
          end else if ((RX_TIMEOUT != 0) && (idle_cnt == IDLE_LAST)) begin
            // This empty cycle is the RX_TIMEOUT-th one since the last pop.
            rx_discard = 1'b1;
            rx_state_d = RX_IDLE;
          end
        end
        RX_HOLD: begin
          if (rx_word_ready) rx_state_d = RX_IDLE;
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  // Slot index is zero whenever the packer is not collecting.
  always_ff @(posedge clk) begin
    if (reset || flush || rx_discard) begin
      rx_idx <= '0;
    end else if (rx_pop) begin
      rx_idx <= (rx_state_d == RX_HOLD) ? '0 : rx_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush || rx_pop || rx_discard || rx_state != RX_COLLECT) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       rx_word <= '0;
    else if (rx_pop) rx_word[rx_idx*PAYLOAD_BITS +: PAYLOAD_BITS] <= rx_head;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) rx_overrun_q <= 1'b0;
    else if (rx_drop)   rx_overrun_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) rx_timeout_q <= 1'b0;
    else       rx_timeout_q <= rx_discard;
  end

  assign rx_word_valid = (rx_state == RX_HOLD);
  assign rx_word_data  = rx_word;
  assign rx_overrun    = rx_overrun_q;
  assign rx_timeout    = rx_timeout_q;

  // ---------------------------------------------------------------- TX path
  tx_state_t               tx_state;
  tx_state_t               tx_state_d;
  logic                    tx_accept;
  logic                    tx_push;
  logic                    tx_pop;
  logic                    tx_full;
  logic                    tx_empty;
  logic                    tx_ready_q;
  logic                    tx_en_q;
  logic [IDX_W-1:0]        tx_idx;
  logic [WORD_BITS-1:0]    tx_word;
  logic [PAYLOAD_BITS-1:0] tx_byte;
  logic [PAYLOAD_BITS-1:0] tx_head;
  logic [PAYLOAD_BITS-1:0] tx_data_q;

  assign tx_byte = tx_word[tx_idx*PAYLOAD_BITS +: PAYLOAD_BITS];

  sync_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(BUFFER_SIZE)) u_tx_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .write      (tx_push),
    .read       (tx_pop),
    .write_data (tx_byte),
    .read_data  (tx_head),
    .full       (tx_full),
    .empty      (tx_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state;
    tx_accept  = 1'b0;
    tx_push    = 1'b0;
    if (flush) begin
      tx_state_d = TX_IDLE;
    end else begin
      unique case (tx_state)
        TX_IDLE: begin
          if (tx_word_valid && tx_ready_q) begin
            tx_accept  = 1'b1;
            tx_state_d = TX_SEND;
          end
        end
        TX_SEND: begin
          if (!tx_full) begin
            tx_push = 1'b1;
            if (tx_idx == LAST_IDX) tx_state_d = TX_IDLE;
          end
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_accept) tx_word <= tx_word_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush || tx_accept) tx_idx <= '0;
    else if (tx_push)                tx_idx <= tx_idx + IDX_W'(1);
  end

  // Registered so ready stays low throughout reset and rises on the first
  // edge after reset is released.
  always_ff @(posedge clk) begin
    if (reset) tx_ready_q <= 1'b0;
    else       tx_ready_q <= (tx_state_d == TX_IDLE);
  end

  // The !tx_en_q term covers the cycle before the transmitter raises busy.
  assign tx_pop = !flush && !uart_tx_busy && !tx_empty && !tx_en_q;

  always_ff @(posedge clk) begin
    if (reset || flush) tx_en_q <= 1'b0;
    else                tx_en_q <= tx_pop;
  end

  always_ff @(posedge clk) begin
    if (reset)       tx_data_q <= '0;
    else if (tx_pop) tx_data_q <= tx_head;
  end

  assign tx_word_ready = tx_ready_q;
  assign uart_tx_en    = tx_en_q;
  assign uart_tx_data  = tx_data_q;

  // ------------------------------------------------------------- statistics
`ifdef UART_WORD_LINK_STATS_EN
  logic [CNT_BITS-1:0] overrun_cnt;
  logic [CNT_BITS-1:0] timeout_cnt;

  // Counters survive flush; only reset clears them. Both saturate.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      if (rx_drop && (overrun_cnt != '1))    overrun_cnt <= overrun_cnt + CNT_BITS'(1);
      if (rx_discard && (timeout_cnt != '1)) timeout_cnt <= timeout_cnt + CNT_BITS'(1);
    end
  end

  assign rx_overrun_count = overrun_cnt;
  assign rx_timeout_count = timeout_cnt;
`else
  assign rx_overrun_count = '0;
  assign rx_timeout_count = '0;
`endif

endmodule

// File: tb/tb_uart_word_link.sv
// Scoreboard bench for uart_word_link (RX_TIMEOUT=100, BUFFER_SIZE=8).
// Stimulus pushes expected words/bytes into queues; monitors pop and compare
// whenever the DUT hands over a word or strobes a byte.
module tb_uart_word_link;

  localparam int PB = 8;
  localparam int WB = 4;
  localparam int CB = 16;
`ifdef UART_WORD_LINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          uart_rx_valid = 1'b0;
  logic [PB-1:0] uart_rx_data = '0;
  logic          uart_tx_busy = 1'b0;
  logic          uart_tx_en;
  logic [PB-1:0] uart_tx_data;
  logic          rx_word_valid;
  logic          rx_word_ready = 1'b0;
  logic [31:0]   rx_word_data;
  logic          tx_word_valid = 1'b0;
  logic          tx_word_ready;
  logic [31:0]   tx_word_data = '0;
  logic          rx_overrun;
  logic          rx_timeout;
  logic [CB-1:0] rx_overrun_count;
  logic [CB-1:0] rx_timeout_count;

  always #5 clk = ~clk;

  uart_word_link #(
    .PAYLOAD_BITS (PB),
    .WORD_BYTES   (WB),
    .BUFFER_SIZE  (8),
    .RX_TIMEOUT   (100),
    .CNT_BITS     (CB)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .uart_rx_valid    (uart_rx_valid),
    .uart_rx_data     (uart_rx_data),
    .uart_tx_busy     (uart_tx_busy),
    .uart_tx_en       (uart_tx_en),
    .uart_tx_data     (uart_tx_data),
    .rx_word_valid    (rx_word_valid),
    .rx_word_ready    (rx_word_ready),
    .rx_word_data     (rx_word_data),
    .tx_word_valid    (tx_word_valid),
    .tx_word_ready    (tx_word_ready),
    .tx_word_data     (tx_word_data),
    .rx_overrun       (rx_overrun),
    .rx_timeout       (rx_timeout),
    .rx_overrun_count (rx_overrun_count),
    .rx_timeout_count (rx_timeout_count)
  );

  logic [31:0] rx_q[$];
  logic [7:0]  tx_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_ovr = 0;
  int          exp_to = 0;
  int          busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_counts(input string name);
    check({name, "_ovr_cnt"}, 64'(rx_overrun_count), STATS ? 64'(exp_ovr) : 64'd0);
    check({name, "_to_cnt"},  64'(rx_timeout_count), STATS ? 64'(exp_to)  : 64'd0);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    tick();
    uart_rx_valid = 1'b0;
  endtask

  task automatic rx_word(input logic [31:0] w);
    for (int k = 0; k < WB; k++) rx_byte(w[8*k +: 8]);
  endtask

  // Offers a word and waits for the handshake; nexp = bytes expected on the line.
  task automatic send_tx_word(input logic [31:0] w, input int nexp);
    bit acc = 1'b0;
    for (int k = 0; k < nexp; k++) tx_q.push_back(w[8*k +: 8]);
    tx_word_valid = 1'b1;
    tx_word_data  = w;
    for (int i = 0; i < 300 && !acc; i++) begin
      acc = tx_word_ready;
      tick();
    end
    tx_word_valid = 1'b0;
    check("tx_accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((rx_q.size() != 0 || tx_q.size() != 0) && n < 1000) begin
      tick();
      n++;
    end
    check(name, 64'(rx_q.size() + tx_q.size()), 64'd0);
  endtask

  // Transmitter model: busy for 10 cycles after each strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (busy_cnt > 0) busy_cnt--;
      if (uart_tx_en) busy_cnt = 10;
      uart_tx_busy = (busy_cnt != 0);
    end
  end

  // Monitor: compares every handed-over word and every transmitted byte.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && rx_word_valid && rx_word_ready) begin
        if (rx_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rx_word: got 0x%0h, expected no word", rx_word_data);
        end else begin
          check("rx_word", 64'(rx_word_data), 64'(rx_q.pop_front()));
        end
      end
      if (uart_tx_en) begin
        if (tx_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL tx_byte: got 0x%0h, expected no strobe", uart_tx_data);
        end else begin
          check("tx_byte", 64'(uart_tx_data), 64'(tx_q.pop_front()));
        end
      end
    end
  end

  initial begin
    // ---- reset values
    tick(3);
    check("rst_rx_valid", 64'(rx_word_valid), 64'd0);
    check("rst_tx_ready", 64'(tx_word_ready), 64'd0);
    check("rst_tx_en",    64'(uart_tx_en),    64'd0);
    check("rst_tx_data",  64'(uart_tx_data),  64'd0);
    check("rst_rx_data",  64'(rx_word_data),  64'd0);
    check("rst_overrun",  64'(rx_overrun),    64'd0);
    check("rst_timeout",  64'(rx_timeout),    64'd0);
    check_counts("rst");
    reset = 1'b0;
    tick();
    check("rst_release_ready", 64'(tx_word_ready), 64'd1);

    // ---- basic word, ready high: valid one cycle after the pop of byte 4
    rx_word_ready = 1'b1;
    rx_q.push_back(32'h44332211);
    rx_word(32'h44332211);
    check("rx_lat_n",   64'(rx_word_valid), 64'd0);
    tick();
    check("rx_lat_n1",  64'(rx_word_valid), 64'd1);
    check("rx_data_n1", 64'(rx_word_data),  64'h44332211);
    tick();
    check("rx_one_cycle", 64'(rx_word_valid), 64'd0);

    // ---- overrun: packer held in RX_HOLD, 9 bytes into an 8-deep FIFO
    rx_word_ready = 1'b0;
    rx_q.push_back(32'hA4A3A2A1);
    rx_word(32'hA4A3A2A1);
    tick(2);
    check("hold_valid", 64'(rx_word_valid), 64'd1);
    for (int i = 0; i < 9; i++) begin
      rx_byte(8'(8'hB0 + i));
      if (i == 7) check("ovr_before_9th", 64'(rx_overrun), 64'd0);
    end
    exp_ovr = 1;
    check("ovr_sticky", 64'(rx_overrun), 64'd1);
    check("hold_data",  64'(rx_word_data), 64'hA4A3A2A1);
    check_counts("ovr");
    rx_q.push_back(32'hB3B2B1B0);
    rx_q.push_back(32'hB7B6B5B4);
    rx_word_ready = 1'b1;
    wait_drain("ovr_drain");

    // ---- timeout: 2 bytes then silence; 2nd byte sampled at N, popped N+1
    rx_byte(8'hC1);
    rx_byte(8'hC2);
    tick(100);
    check("to_before", 64'(rx_timeout), 64'd0);
    tick();
    exp_to = 1;
    check("to_pulse", 64'(rx_timeout), 64'd1);
    check_counts("to");
    tick();
    check("to_one_cycle", 64'(rx_timeout), 64'd0);
    rx_q.push_back(32'hD4D3D2D1);
    rx_word(32'hD4D3D2D1);
    wait_drain("to_next_word");

    // ---- TX unpack: accept at M, strobe after M+2, ready back after M+4
    check("tx_ready_idle", 64'(tx_word_ready), 64'd1);
    send_tx_word(32'hDEADBEEF, 4);
    check("tx_ready_m",  64'(tx_word_ready), 64'd0);
    tick();
    check("tx_en_m1",    64'(uart_tx_en),    64'd0);
    tick();
    check("tx_en_m2",    64'(uart_tx_en),    64'd1);
    check("tx_data_m2",  64'(uart_tx_data),  64'hEF);
    tick();
    check("tx_ready_m3", 64'(tx_word_ready), 64'd0);
    tick();
    check("tx_ready_m4", 64'(tx_word_ready), 64'd1);
    wait_drain("tx_drain");

    // ---- back-to-back words overfill the TX FIFO and stall the unpacker
    send_tx_word(32'h03020100, 4);
    send_tx_word(32'h07060504, 4);
    send_tx_word(32'h0B0A0908, 4);
    wait_drain("tx_stall_drain");
    tick(12);

    // ---- flush mid-RX_COLLECT and mid-TX_SEND
    rx_byte(8'hE1);
    rx_byte(8'hE2);
    send_tx_word(32'h55667788, 1);
    tick(2);
    check("fl_tx_en_before",   64'(uart_tx_en), 64'd1);
    check("fl_overrun_before", 64'(rx_overrun), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_tx_en",     64'(uart_tx_en),    64'd0);
    check("fl_rx_valid",  64'(rx_word_valid), 64'd0);
    check("fl_overrun",   64'(rx_overrun),    64'd0);
    check("fl_rx_empty",  64'(dut.rx_empty),  64'd1);
    check("fl_tx_empty",  64'(dut.tx_empty),  64'd1);
    check("fl_tx_ready",  64'(tx_word_ready), 64'd1);
    check_counts("fl");
    tick(150);
    check_counts("fl_quiet");
    rx_q.push_back(32'hF4F3F2F1);
    rx_word(32'hF4F3F2F1);
    wait_drain("fl_recover");
    tick(20);

    // ---- reset mid-transfer
    send_tx_word(32'h12345678, 1);
    rx_byte(8'h99);
    tick();
    check("rs_tx_en_before", 64'(uart_tx_en), 64'd1);
    reset = 1'b1;
    tick();
    exp_ovr = 0;
    exp_to  = 0;
    check("rs_rx_valid", 64'(rx_word_valid), 64'd0);
    check("rs_tx_ready", 64'(tx_word_ready), 64'd0);
    check("rs_tx_en",    64'(uart_tx_en),    64'd0);
    check("rs_tx_data",  64'(uart_tx_data),  64'd0);
    check("rs_rx_data",  64'(rx_word_data),  64'd0);
    check("rs_overrun",  64'(rx_overrun),    64'd0);
    check("rs_timeout",  64'(rx_timeout),    64'd0);
    check_counts("rs");
    tick();
    reset = 1'b0;
    tick();
    check("rs_release_ready", 64'(tx_word_ready), 64'd1);
    rx_q.push_back(32'h0DF0ADBA);
    rx_word(32'h0DF0ADBA);
    send_tx_word(32'hCAFE0042, 4);
    wait_drain("rs_recover");
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
